sequenciador_ula: RTL and testbench

Command sequencer directly upstream of the 8-bit ALU.
- Accepts {opcode, a, b} commands over a valid/ready handshake.
- Drives the ALU inputs and holds them stable for the ALU's fixed register latency.
- Samples the ALU result and carry/borrow flag, then presents them on a valid/ready result port.
- Guarantees that only one operation is in flight and that ALU inputs never change mid-operation.

---
 rtl/seq_ula_pkg.sv | 24 ++
 rtl/sequenciador_ula_contador_espera.sv | 28 ++
 rtl/sequenciador_ula.sv | 133 +++++++++++++
 tb/tb_sequenciador_ula.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ula_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, opcode check and FSM states.
package seq_ula_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_SOMA  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOT   = 3'b011;
  localparam logic [OP_W-1:0] OP_IGUAL = 3'b110;
  localparam logic [OP_W-1:0] OP_DIF   = 3'b111;

  typedef enum logic [1:0] {
    StOcioso    = 2'd0,
    StEspera    = 2'd1,
    StResultado = 2'd2
  } estado_t;

  // Codes 100 and 101 have no driver inside the ALU.
  function automatic logic opcode_valido(input logic [OP_W-1:0] op);
    return !((op == 3'b100) || (op == 3'b101));
  endfunction

endpackage

// File: rtl/sequenciador_ula_contador_espera.sv
// Loadable down-counter that times the ALU register latency; zero flags expiry.
module contador_espera #(
  parameter int unsigned LATENCIA = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic carrega,
  input  logic decrementa,
  output logic zero
);

  localparam int unsigned W = (LATENCIA < 1) ? 1 : $clog2(LATENCIA + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (carrega) begin
      cnt_q <= W'(LATENCIA);
    end else if (decrementa && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sequenciador_ula.sv
// Single-outstanding command sequencer in front of the registered 8-bit ALU.
// Optional accumulator operand path enabled by defining SEQ_ACUMULADOR_EN.
module sequenciador_ula
  import seq_ula_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned LATENCIA = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_opcode,
  input  logic [N-1:0]    cmd_a,
  input  logic [N-1:0]    cmd_b,
  input  logic            cmd_usa_acc,
  output logic [N-1:0]    ula_a,
  output logic [N-1:0]    ula_b,
  output logic [OP_W-1:0] ula_opcode,
  input  logic [N-1:0]    ula_s,
  input  logic            ula_flag,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N-1:0]    res_s,
  output logic            res_flag,
  output logic [OP_W-1:0] res_opcode,
  output logic            res_erro,
  output logic            ocupado
);

  estado_t         estado_q, estado_d;
  logic [N-1:0]    ula_a_q, ula_b_q, res_s_q;
  logic [OP_W-1:0] ula_op_q, res_op_q;
  logic            res_flag_q, res_erro_q;
  logic [N-1:0]    operando_a;
  logic            aceita, op_ok, captura, conta_zero;

  assign cmd_ready = (estado_q == StOcioso) && !rst;
  assign res_valid = (estado_q == StResultado);
  assign ocupado   = (estado_q != StOcioso);
  assign aceita    = cmd_valid && cmd_ready;
  assign op_ok     = opcode_valido(cmd_opcode);
  assign captura   = (estado_q == StEspera) && conta_zero;

`ifdef SEQ_ACUMULADOR_EN
  logic [N-1:0] acumulador_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acumulador_q <= '0;
    end else if (captura) begin
      acumulador_q <= ula_s;
    end
  end

  assign operando_a = cmd_usa_acc ? acumulador_q : cmd_a;
`else
  logic unused_usa_acc;
  assign unused_usa_acc = cmd_usa_acc;
  assign operando_a     = cmd_a;
`endif

  contador_espera #(
    .LATENCIA(LATENCIA)
  ) u_contador (
    .clk       (clk),
    .rst       (rst),
    .carrega   (aceita && op_ok),
    .decrementa(estado_q == StEspera),
    .zero      (conta_zero)
  );

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StOcioso: begin
        if (cmd_valid && !rst) estado_d = op_ok ? StEspera : StResultado;
      end
      StEspera: begin
        if (conta_zero) estado_d = StResultado;
      end
      StResultado: begin
        if (res_ready) estado_d = StOcioso;
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) estado_q <= StOcioso;
    else     estado_q <= estado_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ula_a_q    <= '0;
      ula_b_q    <= '0;
      ula_op_q   <= '0;
      res_s_q    <= '0;
      res_flag_q <= 1'b0;
      res_op_q   <= '0;
      res_erro_q <= 1'b0;
    end else begin
      if (aceita) begin
        res_op_q <= cmd_opcode;
        if (op_ok) begin
          ula_a_q  <= operando_a;
          ula_b_q  <= cmd_b;
          ula_op_q <= cmd_opcode;
        end else begin
          // No ALU run: ula_* keep the previous operation's values.
          res_s_q    <= '0;
          res_flag_q <= 1'b0;
          res_erro_q <= 1'b1;
        end
      end
      if (captura) begin
        res_s_q    <= ula_s;
        res_flag_q <= ula_flag;
        res_erro_q <= 1'b0;
      end
    end
  end

  assign ula_a      = ula_a_q;
  assign ula_b      = ula_b_q;
  assign ula_opcode = ula_op_q;
  assign res_s      = res_s_q;
  assign res_flag   = res_flag_q;
  assign res_opcode = res_op_q;
  assign res_erro   = res_erro_q;

endmodule

// File: tb/tb_sequenciador_ula.sv
// Self-checking bench for sequenciador_ula with a stand-in two-stage registered ALU.
module tb_sequenciador_ula;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_usa_acc, res_ready;
  logic [2:0] cmd_opcode;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] ula_a, ula_b, ula_s, res_s;
  logic [2:0] ula_opcode, res_opcode;
  logic       ula_flag, cmd_ready, res_valid, res_flag, res_erro, ocupado;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sequenciador_ula #(
    .N(8),
    .LATENCIA(LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_usa_acc(cmd_usa_acc),
    .ula_a      (ula_a),
    .ula_b      (ula_b),
    .ula_opcode (ula_opcode),
    .ula_s      (ula_s),
    .ula_flag   (ula_flag),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_s      (res_s),
    .res_flag   (res_flag),
    .res_opcode (res_opcode),
    .res_erro   (res_erro),
    .ocupado    (ocupado)
  );

  // ALU behaviour: {flag, s}; flag is carry for add, borrow for subtract.
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {(a < b), 8'(a - b)};
      3'b010:  return {1'b0, a ^ b};
      3'b011:  return {1'b0, ~a};
      3'b110:  return {1'b0, 7'd0, (a == b)};
      3'b111:  return {1'b0, 7'd0, (a != b)};
      default: return 9'd0;
    endcase
  endfunction

  logic [8:0] alu_p1 = 9'd0, alu_p2 = 9'd0;
  always @(posedge clk) begin
    alu_p1 <= alu_f(ula_opcode, ula_a, ula_b);
    alu_p2 <= alu_p1;
  end
  assign ula_s    = alu_p2[7:0];
  assign ula_flag = alu_p2[8];

  // Reference model state
  logic [7:0] m_ula_a = 8'd0, m_ula_b = 8'd0, m_acc = 8'd0;
  logic [2:0] m_ula_op = 3'd0;
  logic [7:0] e_s;
  logic       e_f, e_e;
  logic [2:0] e_op;
  int         e_lat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic usa, input bit keep, output int waits);
    logic [7:0] ea;
    logic [8:0] r;
    cmd_opcode  = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_usa_acc = usa;
    cmd_valid   = 1'b1;
    waits = 0;
    while (!cmd_ready && waits < 20) begin
      tick();
      waits++;
    end
    chk("cmd_ready_seen", cmd_ready, 1);
    ea = a;
`ifdef SEQ_ACUMULADOR_EN
    if (usa) ea = m_acc;
`endif
    e_op = op;
    if (op == 3'b100 || op == 3'b101) begin
      e_s = 8'd0; e_f = 1'b0; e_e = 1'b1; e_lat = 0;
    end else begin
      r = alu_f(op, ea, b);
      e_s = r[7:0]; e_f = r[8]; e_e = 1'b0; e_lat = LAT + 1;
      m_ula_a = ea; m_ula_b = b; m_ula_op = op;
    end
    tick();
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic collect(input int rdy_delay, output logic [7:0] gs, output logic gf,
                         output logic ge, output int lat);
    int bad;
    lat = 0;
    bad = 0;
    while (!res_valid && lat < 20) begin
      if (ula_a !== m_ula_a || ula_b !== m_ula_b || ula_opcode !== m_ula_op || cmd_ready !== 1'b0)
        bad++;
      tick();
      lat++;
    end
    if (ula_a !== m_ula_a || ula_b !== m_ula_b || ula_opcode !== m_ula_op) bad++;
    chk("ula_stable", bad, 0);
    chk("res_valid_seen", res_valid, 1);
    gs = res_s;
    gf = res_flag;
    ge = res_erro;
    bad = 0;
    for (int i = 0; i < rdy_delay; i++) begin
      tick();
      if (!res_valid || res_s !== gs || res_flag !== gf || res_erro !== ge || cmd_ready !== 1'b0)
        bad++;
    end
    chk("backpressure_hold", bad, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("ocupado_idle", ocupado, 0);
    if (!e_e) m_acc = e_s;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       f;
    logic       e;
    int         lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] gs;
    logic       gf, ge;
    int         lat, w;

    tbl[0] = '{3'b000, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 3};
    tbl[1] = '{3'b001, 8'd5,   8'd10,  8'd251, 1'b1, 1'b0, 3};
    tbl[2] = '{3'b010, 8'hF0,  8'h3C,  8'hCC,  1'b0, 1'b0, 3};
    tbl[3] = '{3'b100, 8'h11,  8'h22,  8'h00,  1'b0, 1'b1, 0};
    tbl[4] = '{3'b011, 8'h0F,  8'h00,  8'hF0,  1'b0, 1'b0, 3};
    tbl[5] = '{3'b110, 8'd9,   8'd9,   8'd1,   1'b0, 1'b0, 3};
    tbl[6] = '{3'b111, 8'd9,   8'd9,   8'd0,   1'b0, 1'b0, 3};
    tbl[7] = '{3'b101, 8'd1,   8'd2,   8'h00,  1'b0, 1'b1, 0};
    tbl[8] = '{3'b001, 8'd10,  8'd5,   8'd5,   1'b0, 1'b0, 3};

    rst = 1'b1; cmd_valid = 1'b0; cmd_usa_acc = 1'b0; res_ready = 1'b0;
    cmd_opcode = 3'd0; cmd_a = 8'd0; cmd_b = 8'd0;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_ula", {ula_a, ula_b, ula_opcode}, 0);
    chk("rst_res", {res_s, res_flag, res_opcode, res_erro}, 0);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0, w);
      collect(0, gs, gf, ge, lat);
      chk("vec_s", gs, tbl[i].s);
      chk("vec_flag", gf, tbl[i].f);
      chk("vec_erro", ge, tbl[i].e);
      chk("vec_lat", lat, tbl[i].lat);
      chk("vec_opcode", res_opcode, tbl[i].op);
    end

    // Backpressure with a second command waiting the whole time
    issue(3'b000, 8'd20, 8'd22, 1'b0, 1'b1, w);
    cmd_a = 8'd1; cmd_b = 8'd2;
    collect(5, gs, gf, ge, lat);
    chk("bp_s", gs, 8'd42);
    chk("bp_cmd_ready_after", cmd_ready, 1);
    issue(3'b000, 8'd1, 8'd2, 1'b0, 1'b0, w);
    chk("bp_accept_1cyc", w, 0);
    chk("bp_second_ula_a", ula_a, 8'd1);
    collect(0, gs, gf, ge, lat);
    chk("bp_second_s", gs, 8'd3);

    // Reset one cycle after accept, mid-wait
    issue(3'b000, 8'd50, 8'd60, 1'b0, 1'b0, w);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_ocupado", ocupado, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_outputs", {ula_a, ula_b, ula_opcode, res_s, res_flag, res_opcode, res_erro}, 0);
    rst = 1'b0;
    m_ula_a = 8'd0; m_ula_b = 8'd0; m_ula_op = 3'd0; m_acc = 8'd0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    w = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid) w++;
    end
    chk("post_rst_no_result", w, 0);

`ifdef SEQ_ACUMULADOR_EN
    issue(3'b000, 8'd3, 8'd4, 1'b0, 1'b0, w);
    collect(0, gs, gf, ge, lat);
    chk("acc_first", gs, 8'd7);
    issue(3'b000, 8'd99, 8'd10, 1'b1, 1'b0, w);
    chk("acc_ula_a", ula_a, 8'd7);
    collect(0, gs, gf, ge, lat);
    chk("acc_chain", gs, 8'd17);
`endif

    // Randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
            1'b0, w);
      collect(int'($urandom_range(0, 3)), gs, gf, ge, lat);
      chk("rnd_s", gs, e_s);
      chk("rnd_flag", gf, e_f);
      chk("rnd_erro", ge, e_e);
      chk("rnd_lat", lat, e_lat);
      chk("rnd_opcode", res_opcode, e_op);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
